// File: rtl/mux21_arb_pkg.sv
// mux21_arb_pkg: state encoding, requester indices and round-robin pick for the Mux21 arbiter
package mux21_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // A lone requester wins outright; on a tie the side that did not own last wins.
    function automatic logic pick2(input logic [1:0] req, input logic last);
        return (req == 2'b11) ? ~last : req[1];
    endfunction
endpackage

// File: rtl/Mux21.sv
// Mux21: 1-bit 2:1 data mux, i_sel=1 passes i_d1
module Mux21 (
    input  logic i_d0,
    input  logic i_d1,
    input  logic i_sel,
    output logic o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/arb_hold_timer.sv
// arb_hold_timer: ownership length counter, loads to 1 on grant and saturates at MAX_HOLD
module arb_hold_timer #(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_inc,
    output logic o_expire
);
    localparam int W = $clog2(MAX_HOLD + 1);

    logic [W-1:0] r_cnt;

    assign o_expire = (r_cnt == W'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= W'(1);
        else if (i_inc && !o_expire)
            r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/mux21_arbiter.sv
// mux21_arbiter: round-robin owner of a shared 2:1 mux with hold limit and turnaround gap
module mux21_arbiter
    import mux21_arb_pkg::*;
#(
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       sel,
    output logic       busy,
    output logic       preempt
);
    state_t     r_state;
    logic [1:0] r_grant;
    logic       r_sel;
    logic       r_busy;
    logic       r_preempt;
    logic       r_last;
    logic [3:0] r_gap;
    logic       w_expire;
    logic       w_pre;
    logic       w_rel;
    logic       w_arb;
    logic       w_win;
    logic       w_load;
    logic       w_inc;

    // While owning, the current owner is the "last" side for a direct handoff.
    always_comb begin
        w_pre  = (r_state == OWN) && req[r_sel] && w_expire && req[~r_sel];
        w_rel  = (r_state == OWN) && (!req[r_sel] || w_pre);
        w_arb  = (r_state == IDLE) || (r_state == GAP && r_gap == 4'd0) || (w_rel && GAP_CYCLES == 0);
        w_win  = pick2(req, (r_state == OWN) ? r_sel : r_last);
        w_load = w_arb && (req != 2'b00);
        w_inc  = (r_state == OWN) && !w_rel;
    end

    arb_hold_timer #(.MAX_HOLD(MAX_HOLD)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_inc    (w_inc),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_sel     <= REQ0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_last    <= REQ1;
            r_gap     <= 4'd0;
        end else begin
            r_preempt <= w_pre;
            if (w_rel)
                r_last <= r_sel;
            if (w_load) begin
                r_state <= OWN;
                r_grant <= w_win ? 2'b10 : 2'b01;
                r_sel   <= w_win;
                r_busy  <= 1'b1;
            end else if (w_arb) begin
                r_state <= IDLE;
                r_grant <= 2'b00;
                r_busy  <= 1'b0;
            end else if (w_rel) begin
                r_state <= GAP;
                r_grant <= 2'b00;
                r_gap   <= 4'(GAP_CYCLES - 1);
            end else if (r_state == GAP)
                r_gap <= r_gap - 4'd1;
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign preempt = r_preempt;
endmodule

// File: tb/tb_mux21_arbiter.sv
// tb_mux21_arbiter: scoreboard bench for two arbiters (gap=1 and direct handoff) each feeding a Mux21
module tb_mux21_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_a = 2'b00;
    logic [1:0] req_b = 2'b00;
    logic [1:0] mux_in = 2'b10;
    logic [1:0] grant_a, grant_b;
    logic       sel_a, sel_b, busy_a, busy_b, preempt_a, preempt_b, mux_a, mux_b;
    logic [5:0] sb [$];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    mux21_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .grant(grant_a), .sel(sel_a), .busy(busy_a), .preempt(preempt_a)
    );
    Mux21 u_mux_a (.i_d0(mux_in[0]), .i_d1(mux_in[1]), .i_sel(sel_a), .o_y(mux_a));

    mux21_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .grant(grant_b), .sel(sel_b), .busy(busy_b), .preempt(preempt_b)
    );
    Mux21 u_mux_b (.i_d0(mux_in[0]), .i_d1(mux_in[1]), .i_sel(sel_b), .o_y(mux_b));

    // Expected word per cycle: {grant[1:0], sel, busy, preempt, mux_out}
    task automatic apply_reset();
        rst = 1'b1;
        req_a = 2'b00;
        req_b = 2'b00;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        logic [1:0] rq [3];
        logic [5:0] ex [3];
        rq = '{2'b11, 2'b00, 2'b00};
        ex = '{6'b010100, 6'b000100, 6'b000000};
        rst = 1'b1;
        req_a = 2'b11;
        req_b = 2'b11;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({grant_a, sel_a, busy_a, preempt_a, mux_a} !== 6'b000000) begin
            n_errors++;
            $display("FAIL reset_a got %b exp %b", {grant_a, sel_a, busy_a, preempt_a, mux_a}, 6'b000000);
        end
        n_checks++;
        if ({grant_b, sel_b, busy_b, preempt_b, mux_b} !== 6'b000000) begin
            n_errors++;
            $display("FAIL reset_b got %b exp %b", {grant_b, sel_b, busy_b, preempt_b, mux_b}, 6'b000000);
        end
        rst = 1'b0;
        req_b = 2'b00;
        for (int i = 0; i < 3; i++) begin
            req_a = rq[i];
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({grant_a, sel_a, busy_a, preempt_a, mux_a} !== e) begin
                n_errors++;
                $display("FAIL reset_release cyc%0d got %b exp %b", i, {grant_a, sel_a, busy_a, preempt_a, mux_a}, e);
            end
        end
    endtask

    task automatic test_single();
        logic [5:0] e;
        logic [1:0] rq [6];
        logic [5:0] ex [6];
        rq = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        ex = '{6'b010100, 6'b010100, 6'b010100, 6'b000100, 6'b000000, 6'b000000};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            req_a = rq[i];
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({grant_a, sel_a, busy_a, preempt_a, mux_a} !== e) begin
                n_errors++;
                $display("FAIL single cyc%0d got %b exp %b", i, {grant_a, sel_a, busy_a, preempt_a, mux_a}, e);
            end
        end
    endtask

    task automatic test_mux();
        logic [5:0] e;
        logic [1:0] rq [6];
        logic [5:0] ex [6];
        rq = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};
        ex = '{6'b010100, 6'b010100, 6'b000100, 6'b101101, 6'b001101, 6'b001001};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            req_a = rq[i];
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({grant_a, sel_a, busy_a, preempt_a, mux_a} !== e) begin
                n_errors++;
                $display("FAIL mux_tie cyc%0d got %b exp %b", i, {grant_a, sel_a, busy_a, preempt_a, mux_a}, e);
            end
        end
    endtask

    task automatic test_preempt();
        logic [5:0] e;
        logic [1:0] rq [11];
        logic [5:0] ex [11];
        rq = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        ex = '{6'b010100, 6'b010100, 6'b010100, 6'b010100, 6'b000110, 6'b101101,
               6'b101101, 6'b001101, 6'b010100, 6'b000100, 6'b000000};
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            req_a = rq[i];
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({grant_a, sel_a, busy_a, preempt_a, mux_a} !== e) begin
                n_errors++;
                $display("FAIL preempt cyc%0d got %b exp %b", i, {grant_a, sel_a, busy_a, preempt_a, mux_a}, e);
            end
        end
    endtask

    task automatic test_drop_at_expiry();
        logic [5:0] e;
        logic [1:0] rq [8];
        logic [5:0] ex [8];
        rq = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};
        ex = '{6'b010100, 6'b010100, 6'b010100, 6'b010100, 6'b000100, 6'b101101, 6'b001101, 6'b001001};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            req_a = rq[i];
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({grant_a, sel_a, busy_a, preempt_a, mux_a} !== e) begin
                n_errors++;
                $display("FAIL drop_at_expiry cyc%0d got %b exp %b", i, {grant_a, sel_a, busy_a, preempt_a, mux_a}, e);
            end
        end
    endtask

    task automatic test_alone();
        logic [5:0] e;
        apply_reset();
        for (int i = 0; i < 22; i++) begin
            req_a = (i < 20) ? 2'b01 : 2'b00;
            sb.push_back((i < 20) ? 6'b010100 : (i == 20) ? 6'b000100 : 6'b000000);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({grant_a, sel_a, busy_a, preempt_a, mux_a} !== e) begin
                n_errors++;
                $display("FAIL alone cyc%0d got %b exp %b", i, {grant_a, sel_a, busy_a, preempt_a, mux_a}, e);
            end
        end
    endtask

    task automatic test_direct();
        logic [5:0] e;
        logic [1:0] rq [8];
        logic [5:0] ex [8];
        rq = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        ex = '{6'b010100, 6'b010100, 6'b101101, 6'b101101, 6'b101101, 6'b101101, 6'b010110, 6'b010100};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            req_b = rq[i];
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({grant_b, sel_b, busy_b, preempt_b, mux_b} !== e) begin
                n_errors++;
                $display("FAIL direct cyc%0d got %b exp %b", i, {grant_b, sel_b, busy_b, preempt_b, mux_b}, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({grant_b, sel_b, busy_b, preempt_b} !== 5'b00000) begin
            n_errors++;
            $display("FAIL async_reset got %b exp %b", {grant_b, sel_b, busy_b, preempt_b}, 5'b00000);
        end
        @(negedge clk);
        rst = 1'b0;
        req_b = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_mux();
        test_preempt();
        test_drop_at_expiry();
        test_alone();
        test_direct();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
